// File: rtl/pixel_write_queue.sv
// -----------------------------------------------------------------------------
// pixel_write_queue
//
// Decouples the game logic's pixel writes from a framebuffer that may stall.
// In-range pixels are queued in a small FIFO and written to the framebuffer in
// acceptance order. A one-cycle clear request fills the whole screen with a
// single colour. Pixels queued during the fill drain afterwards, so they land
// on top of the fill colour.
//
// Parameters
//   DEPTH       FIFO entries (power of two, >= 2)
//   SCREEN_W    visible width in pixels
//   SCREEN_H    visible height in pixels
//
// Ports
//   clock        single clock, rising edge
//   reset        asynchronous, active-high reset
//   plot         pixel write request
//   X, Y, color  pixel column, row and colour
//   clear_req    one-cycle request to fill the screen
//   clear_color  fill colour, sampled together with clear_req
//   mem_ready    framebuffer accepts a write this cycle
//   in_ready     queue not full (from the registered count only)
//   mem_we       framebuffer write strobe
//   mem_addr     framebuffer address, Y*SCREEN_W + X
//   mem_data     framebuffer colour
//   busy         writes pending or in progress
//   clear_done   one-cycle pulse after the last fill write is accepted
//   overflow     sticky: an in-range pixel was lost to a full FIFO
//   drop_count   saturating count of out-of-range pixels
// -----------------------------------------------------------------------------
module pixel_write_queue #(
  parameter int DEPTH    = 16,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        plot,
  input  logic [8:0]  X,
  input  logic [7:0]  Y,
  input  logic [2:0]  color,
  input  logic        clear_req,
  input  logic [2:0]  clear_color,
  input  logic        mem_ready,
  output logic        in_ready,
  output logic        mem_we,
  output logic [16:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic        busy,
  output logic        clear_done,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          CW        = AW + 1;
  localparam logic [16:0] LAST_ADDR = 17'(SCREEN_W * SCREEN_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_e;

  // The address is computed once at enqueue time, so each entry carries the
  // final framebuffer address rather than raw coordinates.
  typedef struct packed {
    logic [16:0] addr;
    logic [2:0]  color;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [16:0]     clr_cnt_q, clr_cnt_d;
  logic [2:0]      clr_color_q, clr_color_d;
  logic            clear_done_q, clear_done_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_count_q, drop_count_d;

  entry_t          fifo_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Input qualification
  // ---------------------------------------------------------------------------
  logic            full;
  logic            empty;
  logic            in_range;
  logic            push;
  logic            pop;
  logic            drop;
  logic            lost;
  logic [16:0]     push_addr;
  entry_t          head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign in_range = ({23'd0, X} < 32'(SCREEN_W)) && ({24'd0, Y} < 32'(SCREEN_H));

  // Range check wins over full: an out-of-range pixel is counted as dropped
  // even when the FIFO is also full, and never sets overflow.
  assign push = plot &  in_range & ~full;
  assign drop = plot & ~in_range;
  assign lost = plot &  in_range &  full;

  // Constant multiply in 17 bits; for a 320-wide screen this reduces to
  // (Y << 8) + (Y << 6), so no multiplier is needed.
  assign push_addr = 17'(Y) * 17'(SCREEN_W) + 17'(X);

  assign head = fifo_q[rd_ptr_q];

  // DRAIN is only entered with a non-empty FIFO; the empty term is a guard.
  assign pop = (state_q == DRAIN) & mem_ready & ~empty;

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array has no reset; its contents are only visible
  // through the head while DRAIN holds a non-empty FIFO, and skipping the
  // reset lets it map onto plain RAM/LUT storage.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{addr: push_addr, color: color};
    end
  end

  // ---------------------------------------------------------------------------
  // Error bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    overflow_d   = overflow_q | lost;
    drop_count_d = (drop && (drop_count_q != 8'hFF)) ? drop_count_q + 8'd1
                                                     : drop_count_q;
  end

  // ---------------------------------------------------------------------------
  // Controller: next state and framebuffer outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    clr_color_d  = clr_color_q;
    clear_done_d = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_data     = '0;

    unique case (state_q)
      IDLE: begin
        // Pending pixels take priority; a clear is only honoured with the
        // queue empty, and is otherwise dropped rather than remembered.
        if (!empty) begin
          state_d = DRAIN;
        end else if (clear_req) begin
          state_d     = CLEAR;
          clr_cnt_d   = '0;
          clr_color_d = clear_color;
        end
      end

      DRAIN: begin
        mem_we   = 1'b1;
        mem_addr = head.addr;
        mem_data = head.color;
        // Leave only when the last entry goes and nothing replaces it.
        if (pop && (count_q == CW'(1)) && !push) begin
          state_d = IDLE;
        end
      end

      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = clr_cnt_q;
        mem_data = clr_color_q;
        if (mem_ready) begin
          if (clr_cnt_q == LAST_ADDR) begin
            state_d      = IDLE;
            clear_done_d = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + 17'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      clr_cnt_q    <= '0;
      clr_color_q  <= '0;
      clear_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_color_q  <= clr_color_d;
      clear_done_q <= clear_done_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  assign in_ready   = ~full;
  assign busy       = (state_q != IDLE) | ~empty;
  assign clear_done = clear_done_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_pixel_write_queue.sv
// -----------------------------------------------------------------------------
// tb_pixel_write_queue
//
// Directed bench for pixel_write_queue with the default 16-entry FIFO on a
// 320x240 screen. Inputs change 1 time unit after a rising edge; outputs are
// sampled at that same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_pixel_write_queue;

  logic        clock;
  logic        reset;
  logic        plot;
  logic [8:0]  X;
  logic [7:0]  Y;
  logic [2:0]  color;
  logic        clear_req;
  logic [2:0]  clear_color;
  logic        mem_ready;
  logic        in_ready;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [2:0]  mem_data;
  logic        busy;
  logic        clear_done;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  pixel_write_queue #(
    .DEPTH   (16),
    .SCREEN_W(320),
    .SCREEN_H(240)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .plot       (plot),
    .X          (X),
    .Y          (Y),
    .color      (color),
    .clear_req  (clear_req),
    .clear_color(clear_color),
    .mem_ready  (mem_ready),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .busy       (busy),
    .clear_done (clear_done),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"},    32'(mem_we),     32'd0);
    check({tag, "_addr"},  32'(mem_addr),   32'd0);
    check({tag, "_data"},  32'(mem_data),   32'd0);
    check({tag, "_rdy"},   32'(in_ready),   32'd1);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_done"},  32'(clear_done), 32'd0);
    check({tag, "_ovf"},   32'(overflow),   32'd0);
    check({tag, "_drop"},  32'(drop_count), 32'd0);
  endtask

  // Single pixel X=5 Y=2 color=3 with the framebuffer always ready.
  task automatic single_pixel(input string tag);
    mem_ready = 1'b1;
    plot = 1'b1; X = 9'd5; Y = 8'd2; color = 3'd3;
    tick();
    plot = 1'b0;
    check({tag, "_we_t1"},   32'(mem_we),   32'd0);
    check({tag, "_busy_t1"}, 32'(busy),     32'd1);
    tick();
    check({tag, "_we_t2"},   32'(mem_we),   32'd1);
    check({tag, "_addr"},    32'(mem_addr), 32'd645);
    check({tag, "_data"},    32'(mem_data), 32'd3);
    tick();
    check({tag, "_we_t3"},   32'(mem_we),   32'd0);
    check({tag, "_busy_t3"}, 32'(busy),     32'd0);
  endtask

  // Bound on the whole run in case the design stops responding.
  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish expected finish before 2000000");
    $fatal(1, "timeout");
  end

  logic [16:0] exp_addr [4];
  logic [2:0]  exp_data [4];
  int          k;

  initial begin
    reset = 1'b1; plot = 1'b0; X = '0; Y = '0; color = '0;
    clear_req = 1'b0; clear_color = '0; mem_ready = 1'b0;

    // Reset state.
    #3;
    check_reset_values("rst0");
    @(negedge clock);
    reset = 1'b0;
    tick();
    check("rst0_idle_we", 32'(mem_we), 32'd0);

    // Single pixel.
    single_pixel("single");

    // Out-of-range pixels are dropped and counted.
    mem_ready = 1'b1;
    plot = 1'b1; X = 9'd320; Y = 8'd0; color = 3'd1;
    tick();
    X = 9'd0; Y = 8'd240;
    tick();
    plot = 1'b0;
    check("range_drop2", 32'(drop_count), 32'd2);
    check("range_we",    32'(mem_we),     32'd0);
    check("range_busy",  32'(busy),       32'd0);
    tick();
    check("range_we2",   32'(mem_we),     32'd0);

    // Fill the queue with the framebuffer stalled.
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      plot = 1'b1; X = 9'(i * 3); Y = 8'(i); color = 3'(i);
      tick();
    end
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_ovf0",     32'(overflow), 32'd0);
    // Out-of-range while full: counted as a drop, not an overflow.
    X = 9'd320; Y = 8'd5;
    tick();
    check("fill_drop3",    32'(drop_count), 32'd3);
    check("fill_ovf_rng",  32'(overflow),   32'd0);
    // In-range while full: lost, overflow becomes sticky.
    X = 9'd100; Y = 8'd100; color = 3'd7;
    tick();
    plot = 1'b0;
    check("fill_ovf1",     32'(overflow), 32'd1);
    check("fill_in_rdy2",  32'(in_ready), 32'd0);
    check("fill_hold_we",  32'(mem_we),   32'd1);
    check("fill_hold_adr", 32'(mem_addr), 32'd0);
    mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("fill_drain_we",   32'(mem_we),   32'd1);
      check("fill_drain_addr", 32'(mem_addr), 32'(i * 323));
      check("fill_drain_data", 32'(mem_data), 32'(i % 8));
      tick();
    end
    check("fill_end_we",   32'(mem_we),   32'd0);
    check("fill_end_busy", 32'(busy),     32'd0);
    check("fill_end_rdy",  32'(in_ready), 32'd1);
    check("fill_end_ovf",  32'(overflow), 32'd1);

    // Drop counter saturates.
    for (int i = 0; i < 300; i++) begin
      plot = 1'b1;
      case (i % 3)
        0:       begin X = 9'd511; Y = 8'd0;   end
        1:       begin X = 9'd0;   Y = 8'd255; end
        default: begin X = 9'd320; Y = 8'd239; end
      endcase
      tick();
    end
    plot = 1'b0;
    check("sat_drop",  32'(drop_count), 32'd255);
    check("sat_we",    32'(mem_we),     32'd0);
    check("sat_busy",  32'(busy),       32'd0);

    // Stalled drain with mem_ready toggling; a clear request during DRAIN is
    // ignored.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      plot = 1'b1; X = 9'(10 + i); Y = 8'(100 + i); color = 3'(i + 1);
      exp_addr[i] = 17'((100 + i) * 320 + 10 + i);
      exp_data[i] = 3'(i + 1);
      tick();
    end
    plot = 1'b0;
    clear_req = 1'b1; clear_color = 3'd2;
    tick();
    clear_req = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      mem_ready = (c % 2) == 1;
      check("stall_we",   32'(mem_we),   32'd1);
      check("stall_addr", 32'(mem_addr), 32'(exp_addr[k]));
      check("stall_data", 32'(mem_data), 32'(exp_data[k]));
      tick();
      if (mem_ready) k++;
    end
    check("stall_count",   32'(k),          32'd4);
    check("stall_end_we",  32'(mem_we),     32'd0);
    check("stall_end_bsy", 32'(busy),       32'd0);
    tick();
    check("stall_noclr_we",   32'(mem_we),     32'd0);
    check("stall_noclr_bsy",  32'(busy),       32'd0);
    check("stall_noclr_done", 32'(clear_done), 32'd0);

    // Full-screen clear with a pixel queued mid-fill.
    mem_ready = 1'b1;
    clear_req = 1'b1; clear_color = 3'd6;
    tick();
    clear_req = 1'b0;
    check("clr_busy", 32'(busy), 32'd1);
    for (int a = 0; a < 76800; a++) begin
      if (a == 1000) begin
        plot = 1'b1; X = 9'd319; Y = 8'd239; color = 3'd5;
      end else begin
        plot = 1'b0;
      end
      check("clr_addr", 32'(mem_addr),   32'(a));
      check("clr_data", 32'(mem_data),   32'd6);
      check("clr_we",   32'(mem_we),     32'd1);
      check("clr_done", 32'(clear_done), 32'd0);
      tick();
    end
    plot = 1'b0;
    check("clr_done_pulse", 32'(clear_done), 32'd1);
    check("clr_done_we",    32'(mem_we),     32'd0);
    tick();
    check("clr_done_low",   32'(clear_done), 32'd0);
    check("clr_px_we",      32'(mem_we),     32'd1);
    check("clr_px_addr",    32'(mem_addr),   32'd76799);
    check("clr_px_data",    32'(mem_data),   32'd5);
    tick();
    check("clr_end_we",     32'(mem_we),     32'd0);
    check("clr_end_busy",   32'(busy),       32'd0);
    check("clr_end_done",   32'(clear_done), 32'd0);

    // Reset in the middle of a fill, with a pixel waiting behind it.
    clear_req = 1'b1; clear_color = 3'd6;
    tick();
    clear_req = 1'b0;
    for (int a = 0; a < 1000; a++) begin
      if (a == 10) begin
        plot = 1'b1; X = 9'd1; Y = 8'd1; color = 3'd1;
      end else begin
        plot = 1'b0;
      end
      tick();
    end
    plot = 1'b0;
    check("mid_addr", 32'(mem_addr), 32'd1000);
    check("mid_busy", 32'(busy),     32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("rst1");
    @(negedge clock);
    reset = 1'b0;
    tick();
    tick();
    check("post_rst_we",   32'(mem_we),     32'd0);
    check("post_rst_busy", 32'(busy),       32'd0);
    check("post_rst_done", 32'(clear_done), 32'd0);
    single_pixel("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_write_queue.md
PIXEL_WRITE_QUEUE -- requirements
Module: pixel_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two).
REQ-002 SHALL have parameter SCREEN_W, default 320, visible width in pixels.
REQ-003 SHALL have parameter SCREEN_H, default 240, visible height in pixels.
REQ-004 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port plot  input  1  pixel write request from the game top level.
REQ-007 SHALL have port X  input  9  pixel column.
REQ-008 SHALL have port Y  input  8  pixel row.
REQ-009 SHALL have port color  input  3  pixel colour.
REQ-010 SHALL have port clear_req  input  1  one-cycle request to fill the screen.
REQ-011 SHALL have port clear_color  input  3  fill colour, sampled with clear_req.
REQ-012 SHALL have port mem_ready  input  1  framebuffer accepts a write this cycle.
REQ-013 SHALL have port in_ready  output  1  queue not full.
REQ-014 SHALL have port mem_we  output  1  framebuffer write strobe.
REQ-015 SHALL have port mem_addr  output  17  framebuffer address.
REQ-016 SHALL have port mem_data  output  3  framebuffer colour.
REQ-017 SHALL have port busy  output  1  state is not IDLE or FIFO not empty.
REQ-018 SHALL have port clear_done  output  1  one-cycle pulse when fill completes.
REQ-019 SHALL have port overflow  output  1  sticky: a valid pixel was lost to a full FIFO.
REQ-020 SHALL have port drop_count  output  8  saturating count of out-of-range pixels.

Function
REQ-021 Enqueue: when plot=1, in_ready=1, X<SCREEN_W, Y<SCREEN_H, push {X,Y,color} at that edge.
REQ-022 in_ready SHALL be !full, computed from the registered count only; a pop in the same cycle does not free a slot.
REQ-023 plot=1 with X>=SCREEN_W or Y>=SCREEN_H: no push, drop_count+1, saturates at 255; range check takes precedence over full.
REQ-024 plot=1 with an in-range pixel while full: no push, overflow set to 1 until reset.
REQ-025 Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
REQ-026 Address: mem_addr = Y*SCREEN_W + X, computed at 17 bits without truncation; Y*320 is (Y<<8)+(Y<<6).
REQ-027 FSM states: IDLE, DRAIN, CLEAR.
REQ-028 IDLE: mem_we=0; FIFO not empty -> DRAIN; else accepted clear_req -> CLEAR.
REQ-029 clear_req is accepted only in IDLE with FIFO empty; otherwise it is ignored, with no latch and no clear_done.
REQ-030 DRAIN: mem_we=1, with mem_addr/mem_data taken from the FIFO head.
REQ-031 DRAIN pop: mem_ready=1 pops the head; if the FIFO becomes empty -> IDLE.
REQ-032 DRAIN hold: mem_ready=0 holds mem_addr/mem_data stable.
REQ-033 CLEAR: mem_we=1, mem_data=latched clear_color, mem_addr = internal counter starting at 0.
REQ-034 CLEAR counter advances by 1 only when mem_ready=1.
REQ-035 CLEAR exit: a write accepted at address SCREEN_W*SCREEN_H-1 (76799) pulses clear_done for the next cycle and the FSM goes to IDLE.
REQ-036 During CLEAR, enqueue still operates; queued pixels drain after the fill, so they overwrite the fill colour.
REQ-037 Ordering: pixels are written in acceptance order; no write is duplicated or skipped.
REQ-038 Latency: a pixel pushed at edge t into an empty FIFO in IDLE appears on mem_we/mem_addr at t+2 (IDLE->DRAIN at t+1 edge).

Reset
REQ-039 reset=1 SHALL immediately force: state IDLE, FIFO empty, pointers 0, mem_we=0, mem_addr=0, mem_data=0, in_ready=1, busy=0, clear_done=0, overflow=0, drop_count=0, clear counter 0.
REQ-040 Reset mid-DRAIN or mid-CLEAR SHALL discard all queued pixels and abort the fill, with no clear_done.

Verification
REQ-041 Single pixel, mem_ready=1: plot X=5 Y=2 color=3 -> mem_we for exactly one cycle, mem_addr=645, mem_data=3, then busy=0.
REQ-042 Fill queue: mem_ready=0, 17 in-range plots -> 16 stored, in_ready=0, overflow=1; then mem_ready=1 -> 16 writes in order.
REQ-043 Range: plot X=320 Y=0, then X=0 Y=240 -> no writes, drop_count=2; 300 more such plots -> drop_count=255.
REQ-044 Clear: clear_req color=6 with mem_ready=1 -> 76800 writes at addresses 0..76799, data 6, single clear_done pulse; a plot X=319 Y=239 issued mid-fill is written to 76799 after the fill.
REQ-045 Stall: DRAIN with mem_ready toggling every other cycle -> mem_addr/mem_data constant while mem_ready=0, with no lost or repeated pixels.
REQ-046 Reset mid-CLEAR at address 1000 -> all outputs at reset values asynchronously, no clear_done; a subsequent plot behaves as in REQ-041.
